// File: rtl/gray_arb_pkg.sv
// Shared constants and state encoding for the gray-memory read arbiter.
// MAX_BURST is also used by the LBP engines to size one 3x3 window.
package gray_arb_pkg;

   localparam int GRAY_AW        = 14;
   localparam int GRAY_DW        = 8;
   localparam int GRAY_MAX_BURST = 9;

   typedef enum logic [1:0] {
      WAIT_RDY = 2'd0,
      ARB      = 2'd1,
      OWN0     = 2'd2,
      OWN1     = 2'd3
   } arb_state_e;

endpackage

// File: rtl/gray_rd_arbiter.sv
// Two-requester round-robin arbiter for the single gray-image read port,
// with a window-sized burst lock and a 2-deep return tag pipeline.
module gray_rd_arbiter
   import gray_arb_pkg::*;
#(
   parameter int AW        = GRAY_AW,
   parameter int DW        = GRAY_DW,
   parameter int MAX_BURST = GRAY_MAX_BURST
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [DW-1:0] gray_data,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          busy,
   output arb_state_e    state_dbg
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   // Handshake: a requester raises mi_req with a stable mi_addr; the read is
   // accepted at the rising edge where mi_req && mi_gnt, and mi_gnt is a
   // same-cycle combinational answer that is never high without mi_req.

   arb_state_e       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             last, last_n;
   logic             own0_ok, own1_ok;
   logic             win0, win1;
   logic             accept, accept_id;
   logic [AW-1:0]    accept_addr;
   logic             tag1, tag2, v2;

   assign own0_ok = (state == OWN0) && m0_req && (cnt < CNT_W'(MAX_BURST));
   assign own1_ok = (state == OWN1) && m1_req && (cnt < CNT_W'(MAX_BURST));

   // On a tie the requester that did not win last time takes the port.
   assign win0 = m0_req && (!m1_req || last);
   assign win1 = m1_req && (!m0_req || !last);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last;
      m0_gnt  = 1'b0;
      m1_gnt  = 1'b0;
      case (state)
         WAIT_RDY: begin
            if (gray_ready) state_n = ARB;
         end
         default: begin
            if (!gray_ready) begin
               state_n = WAIT_RDY;
            end else if (own0_ok) begin
               m0_gnt = 1'b1;
               cnt_n  = cnt + CNT_W'(1);
            end else if (own1_ok) begin
               m1_gnt = 1'b1;
               cnt_n  = cnt + CNT_W'(1);
            end else if (win0) begin
               m0_gnt  = 1'b1;
               state_n = OWN0;
               cnt_n   = CNT_W'(1);
               last_n  = 1'b0;
            end else if (win1) begin
               m1_gnt  = 1'b1;
               state_n = OWN1;
               cnt_n   = CNT_W'(1);
               last_n  = 1'b1;
            end else begin
               state_n = ARB;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= WAIT_RDY;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         last  <= last_n;
      end
   end

   assign accept      = m0_gnt | m1_gnt;
   assign accept_id   = m1_gnt;
   assign accept_addr = m1_gnt ? m1_addr : m0_addr;

   // tag1 travels with gray_req, tag2 with the cycle gray_data is valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gray_req  <= 1'b0;
         gray_addr <= '0;
         tag1      <= 1'b0;
         tag2      <= 1'b0;
         v2        <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         gray_req <= accept;
         if (accept) begin
            gray_addr <= accept_addr;
            tag1      <= accept_id;
         end
         v2        <= gray_req;
         tag2      <= tag1;
         m0_rvalid <= v2 && !tag2;
         m1_rvalid <= v2 && tag2;
         if (v2 && !tag2) m0_rdata <= gray_data;
         if (v2 && tag2)  m1_rdata <= gray_data;
      end
   end

   assign busy      = (state == OWN0) || (state == OWN1) || gray_req || v2;
   assign state_dbg = state;

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Bench for gray_rd_arbiter: behavioural gray memory, per-requester
// expected-data queues, and directed grant-order scenarios.
module tb_gray_rd_arbiter;
   import gray_arb_pkg::*;

   localparam int AW = 14;
   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [DW-1:0] gray_data;
   logic          m0_req, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic          m0_gnt, m1_gnt;
   logic          m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          busy;
   arb_state_e    state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   int rv0_cnt = 0;
   int rv1_cnt = 0;
   logic [DW-1:0] exp0_q[$];
   logic [DW-1:0] exp1_q[$];

   gray_rd_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(9)) dut (
      .clk(clk), .reset(reset), .gray_ready(gray_ready),
      .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
      return (a[7:0] ^ {1'b0, a[13:7]}) + 8'h35;
   endfunction

   // gray memory: data valid the cycle after gray_req
   always @(posedge clk) begin
      if (gray_req) gray_data <= pix(gray_addr);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // scoreboard: push at accept, pop at rvalid
   always @(negedge clk) begin
      check("gnt_onehot", 32'(m0_gnt & m1_gnt), 0);
      check("gnt_wo_req", 32'((m0_gnt & ~m0_req) | (m1_gnt & ~m1_req)), 0);
      if (m0_req && m0_gnt) exp0_q.push_back(pix(m0_addr));
      if (m1_req && m1_gnt) exp1_q.push_back(pix(m1_addr));
      if (m0_rvalid) begin
         rv0_cnt++;
         if (exp0_q.size() == 0) check("rv0_unexpected", 1, 0);
         else check("rv0_data", 32'(m0_rdata), 32'(exp0_q.pop_front()));
      end
      if (m1_rvalid) begin
         rv1_cnt++;
         if (exp1_q.size() == 0) check("rv1_unexpected", 1, 0);
         else check("rv1_data", 32'(m1_rdata), 32'(exp1_q.pop_front()));
      end
   end

   // driver tasks
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic step(output logic g0, output logic g1);
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      next_cyc();
      if (g0 && m0_req) m0_addr = 14'($urandom_range(0, 16383));
      if (g1 && m1_req) m1_addr = 14'($urandom_range(0, 16383));
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      gray_ready = 1'b0;
      m0_req     = 1'b0;
      m1_req     = 1'b0;
      exp0_q.delete();
      exp1_q.delete();
      repeat (2) next_cyc();
      reset      = 1'b1;
      gray_ready = 1'b1;
      next_cyc();
   endtask

   task automatic drain();
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (5) next_cyc();
   endtask

   initial begin
      logic g0, g1;
      logic [AW-1:0] a0;
      logic [1:0] exp_g;
      int rvs;

      // T1: reset state, ready gating, first-access latency
      reset      = 1'b0;
      gray_ready = 1'b0;
      m0_req     = 1'b1;
      m1_req     = 1'b0;
      m0_addr    = 14'($urandom_range(0, 16383));
      m1_addr    = 14'($urandom_range(0, 16383));
      repeat (2) next_cyc();
      @(negedge clk);
      check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
      check("rst_greq", 32'(gray_req), 0);
      check("rst_gaddr", 32'(gray_addr), 0);
      check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
      check("rst_rdata", {16'd0, m1_rdata, m0_rdata}, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(state_dbg), 32'(WAIT_RDY));
      next_cyc();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t1_nordy_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
         check("t1_nordy_greq", 32'(gray_req), 0);
         next_cyc();
      end
      gray_ready = 1'b1;
      step(g0, g1);
      check("t1_gnt_lag", {30'd0, g1, g0}, 0);
      a0 = m0_addr;
      step(g0, g1);
      check("t1_gnt", {30'd0, g1, g0}, 1);
      m0_req = 1'b0;
      @(negedge clk);
      check("t1_greq", 32'(gray_req), 1);
      check("t1_gaddr", 32'(gray_addr), 32'(a0));
      check("t1_rv_early1", 32'(m0_rvalid), 0);
      next_cyc();
      @(negedge clk);
      check("t1_rv_early2", 32'(m0_rvalid), 0);
      next_cyc();
      @(negedge clk);
      check("t1_rvalid", 32'(m0_rvalid), 1);
      check("t1_rdata", 32'(m0_rdata), 32'(pix(a0)));
      check("t1_busy_done", 32'(busy), 0);
      next_cyc();
      drain();

      // T2: both requesting continuously, 9-grant bursts alternate
      do_reset();
      m0_req = 1'b1;
      m1_req = 1'b1;
      for (int k = 0; k < 36; k++) begin
         exp_g = (((k / 9) % 2) == 0) ? 2'b01 : 2'b10;
         step(g0, g1);
         check("t2_owner", {30'd0, g1, g0}, 32'(exp_g));
      end
      drain();

      // T3: m0 drops after 4 grants, m1 takes over, m0 waits out m1's burst
      do_reset();
      for (int k = 0; k < 14; k++) begin
         m0_req = (k != 4);
         m1_req = (k >= 4);
         exp_g  = (k < 4 || k == 13) ? 2'b01 : 2'b10;
         step(g0, g1);
         check("t3_owner", {30'd0, g1, g0}, 32'(exp_g));
      end
      drain();

      // T4: lone requester keeps the port across burst restarts
      do_reset();
      m1_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step(g0, g1);
         check("t4_owner", {30'd0, g1, g0}, 2);
      end
      drain();

      // T5: gray_ready falls mid-burst, outstanding reads still return
      do_reset();
      rvs    = rv0_cnt;
      m0_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(g0, g1);
         check("t5_pre_gnt", {30'd0, g1, g0}, 1);
      end
      gray_ready = 1'b0;
      step(g0, g1);
      check("t5_drop_gnt", {30'd0, g1, g0}, 0);
      @(negedge clk);
      check("t5_busy_inflight", 32'(busy), 1);
      check("t5_gnt_low", {30'd0, m1_gnt, m0_gnt}, 0);
      next_cyc();
      @(negedge clk);
      check("t5_last_rvalid", 32'(m0_rvalid), 1);
      check("t5_busy_idle", 32'(busy), 0);
      next_cyc();
      check("t5_rv_count", 32'(rv0_cnt - rvs), 3);
      drain();

      // T6: reset right after an accept discards the read
      do_reset();
      rvs    = rv0_cnt;
      m0_req = 1'b1;
      step(g0, g1);
      check("t6_gnt", {30'd0, g1, g0}, 1);
      m0_req = 1'b0;
      next_cyc();
      reset = 1'b0;
      exp0_q.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t6_rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
         check("t6_rst_greq", 32'(gray_req), 0);
         check("t6_rst_gaddr", 32'(gray_addr), 0);
         check("t6_rst_rdata", {16'd0, m1_rdata, m0_rdata}, 0);
         check("t6_rst_busy", 32'(busy), 0);
         check("t6_rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
         next_cyc();
      end
      reset = 1'b1;
      repeat (5) next_cyc();
      check("t6_no_rvalid", 32'(rv0_cnt - rvs), 0);

      check("q0_empty", 32'(exp0_q.size()), 0);
      check("q1_empty", 32'(exp1_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
